// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: arbitrates ALU/load writebacks into a FIFO drained onto the register file write port,
// with a pending-write mask and youngest-match forwarding lookup.
module regfile_wb_ctrl #(
   parameter int DEPTH = 4,
   parameter int DW    = 16,
   parameter int AW    = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       alu_valid,
   output logic                       alu_ready,
   input  logic [AW-1:0]              alu_rd,
   input  logic [DW-1:0]              alu_data,
   input  logic                       ld_valid,
   output logic                       ld_ready,
   input  logic [AW-1:0]              ld_rd,
   input  logic [DW-1:0]              ld_data,
   output logic                       regwr,
   output logic [AW-1:0]              add_Rd,
   output logic [DW-1:0]              data_wr,
   output logic [2**AW-1:0]           pend_mask,
   input  logic [AW-1:0]              fwd_addr,
   output logic                       fwd_hit,
   output logic [DW-1:0]              fwd_data,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] rd_q  [DEPTH];
   logic [DW-1:0] dat_q [DEPTH];
   logic [PW-1:0] wp_q, wp_d, rp_q, rp_d, idx;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          last_ld_q, last_ld_d;
   logic          space, gnt_alu, gnt_ld, acc, enq, deq;
   logic [AW-1:0] in_rd;
   logic [DW-1:0] in_dat;

   always_comb begin
      space     = (cnt_q < CW'(DEPTH)) || (cnt_q != '0);
      gnt_alu   = alu_valid && (!ld_valid || last_ld_q);
      gnt_ld    = ld_valid && (!alu_valid || !last_ld_q);
      alu_ready = gnt_alu && space;
      ld_ready  = gnt_ld && space;
      acc       = (alu_valid && alu_ready) || (ld_valid && ld_ready);
      in_rd     = alu_ready ? alu_rd : ld_rd;
      in_dat    = alu_ready ? alu_data : ld_data;
      enq       = acc && (in_rd != '0);
      deq       = cnt_q != '0;
      wp_d      = enq ? wp_q + PW'(1) : wp_q;
      rp_d      = deq ? rp_q + PW'(1) : rp_q;
      cnt_d     = cnt_q + CW'(enq) - CW'(deq);
      last_ld_d = acc ? ld_ready : last_ld_q;
      regwr     = deq;
      add_Rd    = deq ? rd_q[rp_q] : '0;
      data_wr   = deq ? dat_q[rp_q] : '0;
      count     = cnt_q;
   end

   // Walk oldest to youngest so the last match left standing is the youngest.
   always_comb begin
      pend_mask = '0;
      fwd_hit   = 1'b0;
      fwd_data  = '0;
      idx       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rp_q + PW'(i);
         if (CW'(i) < cnt_q) begin
            pend_mask[rd_q[idx]] = 1'b1;
            if (fwd_addr != '0 && rd_q[idx] == fwd_addr) begin
               fwd_hit  = 1'b1;
               fwd_data = dat_q[idx];
            end
         end
      end
      pend_mask[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q      <= '0;
         rp_q      <= '0;
         cnt_q     <= '0;
         last_ld_q <= 1'b1;
      end else begin
         wp_q      <= wp_d;
         rp_q      <= rp_d;
         cnt_q     <= cnt_d;
         last_ld_q <= last_ld_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         rd_q[wp_q]  <= in_rd;
         dat_q[wp_q] <= in_dat;
      end
   end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed and random writeback traffic checked against a queue-based reference model.
module tb_regfile_wb_ctrl;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alu_valid = 1'b0, ld_valid = 1'b0;
   logic        alu_ready, ld_ready, regwr, fwd_hit;
   logic [3:0]  alu_rd = '0, ld_rd = '0, add_Rd, fwd_addr = '0;
   logic [15:0] alu_data = '0, ld_data = '0, data_wr, pend_mask, fwd_data;
   logic [2:0]  count;

   typedef struct {logic [3:0] rd; logic [15:0] d;} ent_t;
   ent_t q[$];
   bit   m_last_ld = 1'b1;
   bit   exp_a, exp_l;
   int   n_vec = 0, n_err = 0;

   regfile_wb_ctrl #(.DEPTH(DEPTH), .DW(16), .AW(4)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
      .regwr(regwr), .add_Rd(add_Rd), .data_wr(data_wr), .pend_mask(pend_mask),
      .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_cycle();
      bit          space, ga, gl, hit;
      logic [15:0] pm, fd;
      space = (q.size() < DEPTH) || (q.size() != 0);
      if (alu_valid && ld_valid) begin
         ga = m_last_ld;
         gl = !m_last_ld;
      end else begin
         ga = alu_valid;
         gl = ld_valid;
      end
      exp_a = ga && space;
      exp_l = gl && space;
      pm = '0; hit = 1'b0; fd = '0;
      foreach (q[i]) begin
         pm[q[i].rd] = 1'b1;
         if (fwd_addr != 0 && q[i].rd == fwd_addr) begin
            hit = 1'b1;
            fd  = q[i].d;
         end
      end
      check("alu_ready", alu_ready, exp_a);
      check("ld_ready", ld_ready, exp_l);
      check("regwr", regwr, q.size() != 0);
      check("add_Rd", add_Rd, q.size() != 0 ? q[0].rd : 4'd0);
      check("data_wr", data_wr, q.size() != 0 ? q[0].d : 16'd0);
      check("count", count, q.size());
      check("pend_mask", pend_mask, pm);
      check("fwd_hit", fwd_hit, hit);
      check("fwd_data", fwd_data, fd);
   endtask

   task automatic drive(input bit av, input logic [3:0] ard, input logic [15:0] ad,
                        input bit lv, input logic [3:0] lrd, input logic [15:0] ldd,
                        input logic [3:0] fa);
      @(negedge clk);
      alu_valid = av; alu_rd = ard; alu_data = ad;
      ld_valid = lv; ld_rd = lrd; ld_data = ldd; fwd_addr = fa;
      #1 check_cycle();
   endtask

   task automatic tick();
      ent_t e;
      @(posedge clk);
      if (q.size() != 0) void'(q.pop_front());
      if (exp_a || exp_l) begin
         e.rd = exp_a ? alu_rd : ld_rd;
         e.d  = exp_a ? alu_data : ld_data;
         if (e.rd != 0) q.push_back(e);
         m_last_ld = exp_l;
      end
   endtask

   task automatic idle(input logic [3:0] fa);
      drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, fa);
   endtask

   initial begin
      bit          av, lv;
      logic [3:0]  ard, lrd, fa;
      logic [15:0] ad, ldd;
      #12;
      check("rst_regwr", regwr, 0);
      check("rst_count", count, 0);
      check("rst_pend", pend_mask, 0);
      check("rst_fwd", {fwd_hit, fwd_data}, 0);
      @(negedge clk) rst = 1'b0;

      drive(1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 16'd0, 4'd5);
      check("beef_ready", alu_ready, 1);
      tick();
      idle(4'd5);
      check("beef_wr", {regwr, add_Rd, data_wr}, {1'b1, 4'd5, 16'hBEEF});
      check("beef_pm", pend_mask, 16'h0020);
      tick();
      idle(4'd5);
      check("beef_done", regwr, 0);
      tick();

      drive(1'b0, 4'd0, 16'd0, 1'b1, 4'd0, 16'hFFFF, 4'd0);
      check("r0_ready", ld_ready, 1);
      tick();
      for (int k = 0; k < 3; k++) begin
         idle(4'd0);
         check("r0_nowr", {regwr, count, fwd_hit}, 0);
         tick();
      end

      for (int n = 1; n <= 4; n++) begin
         drive(1'b1, 4'(n), 16'h0A00 + 16'(n), 1'b1, 4'(8 + n), 16'h0B00 + 16'(n), 4'd0);
         check("cont_gnt", {alu_ready, ld_ready}, (n % 2) ? 2'b10 : 2'b01);
         tick();
      end
      idle(4'd0);
      check("cont_last", {add_Rd, data_wr}, {4'd12, 16'h0B04});
      tick();

      drive(1'b1, 4'd3, 16'h1111, 1'b0, 4'd0, 16'd0, 4'd3);
      tick();
      drive(1'b1, 4'd3, 16'h2222, 1'b0, 4'd0, 16'd0, 4'd3);
      check("fwd_first", data_wr, 16'h1111);
      tick();
      idle(4'd3);
      check("fwd_young", {fwd_hit, fwd_data}, {1'b1, 16'h2222});
      check("fwd_second", data_wr, 16'h2222);
      tick();

      for (int k = 0; k < 20; k++) begin
         drive(1'b1, 4'((k % 15) + 1), 16'($urandom), 1'b0, 4'd0, 16'd0, 4'($urandom_range(0, 15)));
         check("sus_ready", alu_ready, 1);
         check("sus_cnt", count <= 1, 1);
         tick();
      end

      drive(1'b1, 4'd7, 16'h7777, 1'b0, 4'd0, 16'd0, 4'd7);
      tick();
      @(negedge clk);
      alu_valid = 1'b0; ld_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("mrst_regwr", regwr, 0);
      check("mrst_count", count, 0);
      check("mrst_pend", pend_mask, 0);
      q.delete();
      m_last_ld = 1'b1;
      @(negedge clk) rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         idle(4'd7);
         check("mrst_nowr", regwr, 0);
         tick();
      end

      av = 0; lv = 0; ard = 0; lrd = 0; ad = 0; ldd = 0;
      for (int k = 0; k < 400; k++) begin
         if (!(av && !exp_a)) begin
            av = 1'($urandom_range(0, 1)); ard = 4'($urandom_range(0, 15)); ad = 16'($urandom);
         end
         if (!(lv && !exp_l)) begin
            lv = 1'($urandom_range(0, 1)); lrd = 4'($urandom_range(0, 15)); ldd = 16'($urandom);
         end
         fa = 4'($urandom_range(0, 15));
         drive(av, ard, ad, lv, lrd, ldd, fa);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
